touch_adc_ctrl: RTL

Serial front end for the resistive touch-panel ADC (AD7843/ADS7843-class, SPI-style). It watches the panel's pen-interrupt line and, while the pen is down, runs back-to-back 12-bit X/Y conversions over DCLK/CS_n/DIN/DOUT. It publishes the results as `oX_COORD`, `oY_COORD` and `oNEW_COORD`, plus a debounced touch level on `oTOUCH_IRQ`. Its outputs are the coordinate/IRQ inputs consumed by the photo/display-mode logic downstream.

---
 rtl/touch_adc_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/touch_adc_ctrl.sv
// touch_adc_ctrl
// Front end for an ADS7843/AD7843-class resistive touch ADC. While the pen
// is down it runs back-to-back 12-bit X then Y conversions over the
// DCLK/CS_n/DIN/DOUT link. It publishes each completed pair as a whole,
// with a one-cycle oNEW_COORD strobe, and keeps a debounced touch level on
// oTOUCH_IRQ.
//
// Every output comes straight from a flop. Each flop is loaded from a value
// derived from the *next* state, so the outputs line up with the state that
// is current in the same cycle. For example, CS_n is high during the single
// DONE cycle, and it is high on the same edge that oNEW_COORD rises.
module touch_adc_ctrl #(
  parameter int         CLK_DIV    = 25,      // iCLK cycles per DCLK half-period (>= 2)
  parameter int         SAMPLE_GAP = 500000,  // idle cycles between pairs
  parameter logic [7:0] CMD_X      = 8'h90,
  parameter logic [7:0] CMD_Y      = 8'hD0
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iPENIRQ_n,
  input  logic        iADC_DOUT,
  output logic        oADC_DCLK,
  output logic        oADC_CS_n,
  output logic        oADC_DIN,
  output logic [11:0] oX_COORD,
  output logic [11:0] oY_COORD,
  output logic        oNEW_COORD,
  output logic        oTOUCH_IRQ
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // GAP ends with the counter at SAMPLE_GAP. The extra cycle is the pen check.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SAMPLE_GAP);

  // Rising-edge counter values. The count is compared *before* it is
  // incremented, so a value of 9 means "this rising edge is k=10".
  localparam logic [4:0] LAST_EDGE = 5'd24;
  localparam logic [4:0] CAP_FIRST = 5'd9;   // edge k=10 captures D11
  localparam logic [4:0] CAP_LAST  = 5'd20;  // edge k=21 captures D0

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_X,
    ST_CONV_Y,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t state_q, state_d;

  // Synchronizers
  logic pen_meta_q, pen_meta_d;
  logic pen_sync_q, pen_sync_d;
  logic dout_meta_q, dout_meta_d;
  logic dout_sync_q, dout_sync_d;

  // Bit engine
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       edge_q, edge_d;
  logic             dclk_q, dclk_d;
  logic             din_q, din_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [11:0]      shift_q, shift_d;
  logic [11:0]      x_hold_q, x_hold_d;

  // Status and results
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             cs_n_q, cs_n_d;
  logic [11:0]      x_q, x_d;
  logic [11:0]      y_q, y_d;
  logic             new_q, new_d;
  logic             touch_q, touch_d;

  // Decoded controls
  logic       pen;
  logic       in_conv;
  logic       next_conv;
  logic       tick;
  logic       rise_tick;
  logic       fall_tick;
  logic       conv_end;
  logic       start_x;
  logic       start_y;
  logic       conv_start;
  logic [7:0] start_cmd;

  // Shared decode of the current/next state and the divider tick
  always_comb begin
    pen        = ~pen_sync_q;
    in_conv    = (state_q == ST_CONV_X) || (state_q == ST_CONV_Y);
    tick       = (div_q == DIV_LAST);
    rise_tick  = in_conv && tick && !dclk_q;
    fall_tick  = in_conv && tick && dclk_q;
    conv_end   = fall_tick && (edge_q == LAST_EDGE);
    next_conv  = (state_d == ST_CONV_X) || (state_d == ST_CONV_Y);
    start_x    = (state_q != ST_CONV_X) && (state_d == ST_CONV_X);
    start_y    = (state_q == ST_CONV_X) && (state_d == ST_CONV_Y);
    conv_start = start_x || start_y;
    start_cmd  = start_y ? CMD_Y : CMD_X;
  end

  // Two-flop synchronizers for the asynchronous pen line and ADC data
  always_comb begin
    pen_meta_d  = iPENIRQ_n;
    pen_sync_d  = pen_meta_q;
    dout_meta_d = iADC_DOUT;
    dout_sync_d = dout_meta_q;
  end

  // Sequencer next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pen) state_d = ST_CONV_X;
      end
      ST_CONV_X: begin
        if (conv_end) state_d = ST_CONV_Y;
      end
      ST_CONV_Y: begin
        if (conv_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = pen ? ST_CONV_X : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit engine: DCLK generation, command shift-out and data capture
  always_comb begin
    div_d    = div_q;
    dclk_d   = dclk_q;
    edge_d   = edge_q;
    cmd_d    = cmd_q;
    din_d    = din_q;
    shift_d  = shift_q;
    x_hold_d = x_hold_q;

    if (conv_start) begin
      // The start bit goes out on the first cycle of the conversion. The
      // remaining command bits wait in cmd_q for the falling edges.
      div_d   = '0;
      dclk_d  = 1'b0;
      edge_d  = '0;
      cmd_d   = {start_cmd[6:0], 1'b0};
      din_d   = start_cmd[7];
      shift_d = '0;
    end else if (!next_conv) begin
      div_d  = '0;
      dclk_d = 1'b0;
      edge_d = '0;
      cmd_d  = '0;
      din_d  = 1'b0;
    end else begin
      if (tick) begin
        div_d  = '0;
        dclk_d = ~dclk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (rise_tick) begin
        edge_d = edge_q + 5'd1;
        if ((edge_q >= CAP_FIRST) && (edge_q <= CAP_LAST)) begin
          shift_d = {shift_q[10:0], dout_sync_q};
        end
      end
      if (fall_tick) begin
        din_d = cmd_q[7];
        cmd_d = {cmd_q[6:0], 1'b0};
      end
    end

    // X is parked here so the visible pair can switch in a single step.
    if ((state_q == ST_CONV_X) && conv_end) x_hold_d = shift_q;
  end

  // Chip select, published pair, new-pair strobe, touch level and gap timer
  always_comb begin
    cs_n_d  = ~next_conv;
    x_d     = x_q;
    y_d     = y_q;
    new_d   = 1'b0;
    touch_d = touch_q;
    gap_d   = '0;

    if ((state_q == ST_CONV_Y) && (state_d == ST_DONE)) begin
      x_d   = x_hold_q;
      y_d   = shift_q;
      new_d = 1'b1;
    end

    // The ADC disturbs PENIRQ while converting, so the line is trusted only
    // when the link is quiet.
    if ((state_q == ST_IDLE) || (state_q == ST_GAP)) touch_d = pen;

    if ((state_q == ST_GAP) && (state_d == ST_GAP)) gap_d = gap_q + GAP_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_IDLE;
      pen_meta_q  <= 1'b1;
      pen_sync_q  <= 1'b1;
      dout_meta_q <= 1'b0;
      dout_sync_q <= 1'b0;
      div_q       <= '0;
      edge_q      <= '0;
      dclk_q      <= 1'b0;
      din_q       <= 1'b0;
      cmd_q       <= '0;
      shift_q     <= '0;
      x_hold_q    <= '0;
      gap_q       <= '0;
      cs_n_q      <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      new_q       <= 1'b0;
      touch_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pen_meta_q  <= pen_meta_d;
      pen_sync_q  <= pen_sync_d;
      dout_meta_q <= dout_meta_d;
      dout_sync_q <= dout_sync_d;
      div_q       <= div_d;
      edge_q      <= edge_d;
      dclk_q      <= dclk_d;
      din_q       <= din_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      x_hold_q    <= x_hold_d;
      gap_q       <= gap_d;
      cs_n_q      <= cs_n_d;
      x_q         <= x_d;
      y_q         <= y_d;
      new_q       <= new_d;
      touch_q     <= touch_d;
    end
  end

  assign oADC_DCLK  = dclk_q;
  assign oADC_CS_n  = cs_n_q;
  assign oADC_DIN   = din_q;
  assign oX_COORD   = x_q;
  assign oY_COORD   = y_q;
  assign oNEW_COORD = new_q;
  assign oTOUCH_IRQ = touch_q;

endmodule
